// File: rtl/wb_write_sequencer.sv
// wb_write_sequencer: serialises retired-instruction E/M register writes onto a single register-file write port
module wb_write_sequencer #(
  parameter int DATA_W = 64,
  parameter int NREG = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pending,
  output logic              busy
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP = 4'd4;
  typedef enum logic [1:0] {IDLE, WR_E, WR_M} state_t;
  state_t state, state_n, first;
  logic [3:0] dst_e, dst_m, d_e, d_m;
  logic [DATA_W-1:0] val_e, val_m;
  logic [NREG-1:0] pending_n;
  logic accept;
  assign d_e = (icode == 4'h2) ? (cnd ? rB : RNONE) :
               (icode == 4'h3 || icode == 4'h6) ? rB :
               (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
  assign d_m = (icode == 4'h5 || icode == 4'hB) ? rA : RNONE;
  assign wb_ready = !rst && (state != WR_E || dst_m == RNONE);
  assign accept = wb_valid && wb_ready;
  assign busy = state != IDLE;
  always_comb begin
    first = (d_e != RNONE) ? WR_E : (d_m != RNONE) ? WR_M : IDLE;
    state_n = (state == WR_E && dst_m != RNONE) ? WR_M : accept ? first : IDLE;
    rf_we = state == WR_E || state == WR_M;
    rf_waddr = (state == WR_E) ? dst_e : (state == WR_M) ? dst_m : RNONE;
    rf_wdata = (state == WR_E) ? val_e : (state == WR_M) ? val_m : '0;
    pending_n = '0;
    for (int i = 0; i < NREG; i++)
      pending_n[i] = (accept && (d_e == i[3:0] || d_m == i[3:0])) ||
                     (pending[i] && !(rf_we && rf_waddr == i[3:0]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dst_e <= RNONE;
      dst_m <= RNONE;
      val_e <= '0;
      val_m <= '0;
      pending <= '0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      if (accept) begin
        dst_e <= d_e;
        dst_m <= d_m;
        val_e <= valE;
        val_m <= valM;
      end
    end
  end
endmodule

// File: tb/tb_wb_write_sequencer.sv
// tb_wb_write_sequencer: per-cycle vector table plus a bounded hand-written ret sequence
module tb_wb_write_sequencer;
  logic clk = 0, rst = 1, wb_valid = 0, wb_ready, cnd = 0, rf_we, busy;
  logic [3:0] icode = 0, rA = 0, rB = 0, rf_waddr;
  logic [63:0] valE = 0, valM = 0, rf_wdata;
  logic [14:0] pending;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  wb_write_sequencer #(.DATA_W(64), .NREG(15)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .icode(icode), .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .busy(busy)
  );

  typedef struct {
    logic r, v;
    logic [3:0] ic, ra, rb;
    logic c;
    logic [63:0] ve, vm;
    logic rdy, we;
    logic [3:0] wa;
    logic [63:0] wd;
    logic [14:0] pd;
    logic bs;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(input logic r, v, input logic [3:0] ic, ra, rb, input logic c,
                              input logic [63:0] ve, vm, input logic rdy, we, input logic [3:0] wa,
                              input logic [63:0] wd, input logic [14:0] pd, input logic bs);
    mk = '{r, v, ic, ra, rb, c, ve, vm, rdy, we, wa, wd, pd, bs};
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // inputs/expected outputs observed in the same cycle (before its rising edge)
    vq.push_back(mk(1,1,4'h6,0,3,0,'h2A,0,   0,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(1,1,4'h6,0,3,0,'h2A,0,   0,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(1,1,4'h6,0,3,0,'h2A,0,   0,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,1,4'h6,0,3,0,'h2A,0,   1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,1,4'h3,'h2A,  15'h0008,1));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,1,4'hB,2,0,0,'h100,'h55,1,0,4'hF,0,    15'h0000,0));
    vq.push_back(mk(0,1,4'h3,0,1,0,'h11,0,   0,1,4'h4,'h100, 15'h0014,1));
    vq.push_back(mk(0,1,4'h3,0,1,0,'h11,0,   1,1,4'h2,'h55,  15'h0004,1));
    vq.push_back(mk(0,1,4'h3,0,2,0,'h22,0,   1,1,4'h1,'h11,  15'h0002,1));
    vq.push_back(mk(0,1,4'h3,0,3,0,'h33,0,   1,1,4'h2,'h22,  15'h0004,1));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,1,4'h3,'h33,  15'h0008,1));
    vq.push_back(mk(0,1,4'hB,4,0,0,'hAA,'hBB,1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,0,4'h0,0,0,0,'h1,'h2,  0,1,4'h4,'hAA,  15'h0010,1));
    vq.push_back(mk(0,0,4'h0,0,0,0,'h3,'h4,  1,1,4'h4,'hBB,  15'h0000,1));
    vq.push_back(mk(0,1,4'h2,0,5,0,'h5A,0,   1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,1,4'h0,0,0,0,0,0,      1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,1,4'h2,0,5,1,'h5A,0,   1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,1,4'h5,'h5A,  15'h0020,1));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,1,4'h5,7,0,0,0,'h77,   1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,1,4'h7,'h77,  15'h0080,1));
    vq.push_back(mk(0,1,4'hB,6,0,0,'h61,'h62,1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(1,0,4'h0,0,0,0,0,0,      0,1,4'h4,'h61,  15'h0050,1));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,0,4'hF,0,     15'h0000,0));
    vq.push_back(mk(0,0,4'h0,0,0,0,0,0,      1,0,4'hF,0,     15'h0000,0));
    @(posedge clk); #1;
    foreach (vq[i]) begin
      {rst, wb_valid, icode, rA, rB, cnd, valE, valM} =
        {vq[i].r, vq[i].v, vq[i].ic, vq[i].ra, vq[i].rb, vq[i].c, vq[i].ve, vq[i].vm};
      @(negedge clk);
      chk("wb_ready", i, 64'(wb_ready), 64'(vq[i].rdy));
      chk("rf_we", i, 64'(rf_we), 64'(vq[i].we));
      chk("rf_waddr", i, 64'(rf_waddr), 64'(vq[i].wa));
      chk("rf_wdata", i, rf_wdata, vq[i].wd);
      chk("pending", i, 64'(pending), 64'(vq[i].pd));
      chk("busy", i, 64'(busy), 64'(vq[i].bs));
      @(posedge clk); #1;
    end
    // ret: offer once, then wait a bounded number of cycles for its rsp write
    {wb_valid, icode, valE, valM} = {1'b1, 4'h9, 64'hC0DE, 64'h0};
    @(posedge clk); #1;
    wb_valid = 0;
    valE = 64'hDEAD;
    begin
      bit seen = 0;
      for (int k = 0; k < 5 && !seen; k++) begin
        @(negedge clk);
        if (rf_we) begin
          seen = 1;
          chk("ret_waddr", 100, 64'(rf_waddr), 64'h4);
          chk("ret_wdata", 100, rf_wdata, 64'hC0DE);
          chk("ret_pending", 100, 64'(pending), 64'h0010);
        end
        @(posedge clk); #1;
      end
      chk("ret_seen", 100, 64'(seen), 64'h1);
    end
    @(negedge clk);
    chk("ret_idle_pending", 101, 64'(pending), 64'h0);
    chk("ret_idle_busy", 101, 64'(busy), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_write_sequencer.md
# wb_write_sequencer

Write-back controller for the SEQ processor's 15-entry register file. It accepts one retired instruction per handshake with its icode, rA, rB, cnd, valE and valM, and derives the E and M destination registers from the icode. It then drives the register file's single write port, one register per cycle, so that popq's two writes are serialised. It also exports a pending-write mask that decode uses for hazard stalls.

## Interface
Parameters:
- DATA_W, 64, register data width
- NREG, 15, number of architectural registers (index 15 = RNONE)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_valid  in  1  upstream offers an instruction
- wb_ready  out  1  block can accept this cycle
- icode  in  4  instruction code
- rA  in  4  register A field
- rB  in  4  register B field
- cnd  in  1  condition result (used by icode 2 only)
- valE  in  DATA_W  execute result
- valM  in  DATA_W  memory result
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  write address
- rf_wdata  out  DATA_W  write data
- pending  out  NREG  bit i set = write to register i accepted but not yet performed
- busy  out  1  FSM not in IDLE

## Operation
- Destination decode at accept (RNONE = 4'hF, rsp = 4):
  - icode 2 (cmov): dstE = cnd ? rB : F.
  - icode 3 (irmovq) and 6 (OPq): dstE = rB.
  - icode 5 (mrmovq): dstM = rA.
  - icode 8, 9, A (call, ret, pushq): dstE = 4.
  - icode B (popq): dstE = 4, dstM = rA.
  - All other icodes: both F. The instruction is accepted and performs no write.
- A transfer occurs on a rising edge with wb_valid && wb_ready. At that edge the block captures dstE, dstM, valE and valM.
- FSM states: IDLE, WR_E, WR_M.
  - On accept, next state is WR_E if dstE≠F, else WR_M if dstM≠F, else IDLE.
  - WR_E goes to WR_M if a captured dstM≠F. Otherwise it goes to the next instruction's first state if accepting, else IDLE.
  - WR_M goes to the next instruction's first state if accepting, else IDLE.
- Write port:
  - In WR_E: rf_we=1, rf_waddr=dstE, rf_wdata=valE.
  - In WR_M: rf_we=1, rf_waddr=dstM, rf_wdata=valM.
  - In IDLE: rf_we=0, rf_waddr=F, rf_wdata=0.
- popq %rsp (dstE=dstM=4): E is written first, then M, so the final value is valM (M wins).
- wb_ready is combinational from state: 1 in IDLE, in WR_M, and in WR_E when the captured dstM=F. It is 0 in WR_E with an M write still owed, and 0 while rst is high.
- pending:
  - Set bits dstE and dstM (each only if ≠F) at accept.
  - Clear bit rf_waddr at the end of its write cycle.
  - Set and clear of the same bit in the same edge leaves the bit set.
  - Bits stay within [14:0]; register 15 is never written.
- busy = (state≠IDLE).

## Timing
- Reset (sync): state=IDLE, rf_we=0, rf_waddr=F, rf_wdata=0, pending=0, busy=0, and wb_ready=0 during rst.
  - wb_ready rises the first cycle after rst deasserts.
  - All captured fields are cleared.
- rst asserted mid-operation (WR_E or WR_M): the owed writes are dropped, with no write in the cycle after the reset edge, and pending clears.
- Latency: an instruction accepted at edge N drives its first write during cycle N+1. A second write (popq only) follows in cycle N+2.
- Throughput:
  - Single-write instructions: one per cycle, back-to-back.
  - popq: occupies 2 cycles, with a 1-cycle wb_ready low.
  - No-write instructions: one per cycle, FSM stays or returns to IDLE.
- Inputs are sampled only at the accept edge. Later changes to valE/valM do not affect writes already owed.

## Test plan
- Reset: hold rst 3 cycles with wb_valid=1 → wb_ready=0 and rf_we=0 throughout. After release, wb_ready=1, pending=0.
- OPq (icode 6, rB=3, valE=0x2A) accepted at edge N → cycle N+1: rf_we=1, rf_waddr=3, rf_wdata=0x2A. pending[3]=1 during N+1, 0 after.
- popq (icode B, rA=2, valE=0x100, valM=0x55) → N+1 writes reg 4←0x100 with wb_ready=0. N+2 writes reg 2←0x55 with wb_ready=1. popq with rA=4 → final reg 4 write is valM.
- Back-to-back irmovq r1, r2, r3 with wb_valid held high → writes to 1, 2, 3 on three consecutive cycles, wb_ready constantly 1.
- cmov with cnd=0 and icode 0 (halt) → accepted, no rf_we, pending unchanged. cmov with cnd=1, rB=5 → writes reg 5.
- rst asserted in WR_E of a popq → no WR_M write, pending=0, FSM in IDLE after reset release.
